manchester_frame_tx: RTL and testbench

MANCHESTER_FRAME_TX -- requirements
Module: manchester_frame_tx

---
 rtl/manch_pkg.sv | 26 ++
 rtl/manchester_half_enc.sv | 31 +++
 rtl/manchester_frame_tx.sv | 169 ++++++++++++++++
 tb/tb_manchester_frame_tx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/manch_pkg.sv
// Shared encoding constants and FSM state type for the Manchester frame transmitter.
// Defining MANCH_PARITY_EN adds the PAR state used for the per-byte even-parity bit.
package manch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      DATA,
`ifdef MANCH_PARITY_EN
      PAR,
`endif
      GAP
   } state_e;

   localparam logic [7:0] PREAMBLE = 8'h55;
   localparam int         GAP_CLKS = 4;
   localparam logic [1:0] GAP_LAST = 2'(GAP_CLKS - 1);

   // A one bit is sent high-then-low and a zero bit low-then-high.
   localparam logic ONE_FIRST_HALF   = 1'b1;
   localparam logic ONE_SECOND_HALF  = 1'b0;
   localparam logic ZERO_FIRST_HALF  = 1'b0;
   localparam logic ZERO_SECOND_HALF = 1'b1;
   localparam logic IDLE_LEVEL       = 1'b0;

endpackage

// File: rtl/manchester_half_enc.sv
// Registered half-bit encoder: turns an NRZ bit plus half flag into the Manchester line level.
// The line rests at the idle level whenever the encoder is not enabled.
module manchester_half_enc
   import manch_pkg::*;
(
   input  logic clock,
   input  logic rst_b,
   input  logic en_i,
   input  logic nrz_i,
   input  logic half_i,
   output logic line_o
);

   logic line_q, line_d;

   always_comb begin
      line_d = IDLE_LEVEL;
      if (en_i) begin
         if (nrz_i) line_d = half_i ? ONE_SECOND_HALF : ONE_FIRST_HALF;
         else       line_d = half_i ? ZERO_SECOND_HALF : ZERO_FIRST_HALF;
      end
   end

   always_ff @(negedge clock or negedge rst_b) begin
      if (!rst_b) line_q <= IDLE_LEVEL;
      else        line_q <= line_d;
   end

   assign line_o = line_q;

endmodule

// File: rtl/manchester_frame_tx.sv
// Manchester frame transmitter: preamble, LSB-first data bytes, optional parity, trailing gap.
// Defining MANCH_PARITY_EN appends an even-parity bit after every byte.
module manchester_frame_tx
   import manch_pkg::*;
(
   input  logic       clock,
   input  logic       rst_b,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       B_out,
   output logic       busy,
   output logic       underrun
);

   state_e     state_q, state_d;
   logic [2:0] bit_q, bit_d;
   logic       half_q, half_d;
   logic [1:0] gap_q, gap_d;
   logic [7:0] byte_q, byte_d;
   logic       last_q, last_d;
   logic       ready_q, ready_d;
   logic       busy_q, busy_d;
   logic       under_q, under_d;

   logic accept;
   logic dataEnd;
   logic byteEnd;
   logic finalNext;
   logic lineEn;
   logic nrzBit;

   assign accept  = tx_valid && ready_q;
   assign dataEnd = (state_q == DATA) && (bit_q == 3'd7) && half_q;
`ifdef MANCH_PARITY_EN
   assign byteEnd = (state_q == PAR) && half_q;
`else
   assign byteEnd = dataEnd;
`endif

   // Outputs are registered, so tx_ready is derived from where the FSM is about to be.
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      half_d  = half_q;
      gap_d   = gap_q;
      byte_d  = byte_q;
      last_d  = last_q;
      under_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = PRE;
               byte_d  = tx_data;
               last_d  = tx_last;
               bit_d   = 3'd0;
               half_d  = 1'b0;
            end
         end
         PRE: begin
            half_d = ~half_q;
            if (half_q) bit_d = bit_q + 3'd1;
            if ((bit_q == 3'd7) && half_q) state_d = DATA;
         end
         DATA: begin
            half_d = ~half_q;
            if (half_q) bit_d = bit_q + 3'd1;
`ifdef MANCH_PARITY_EN
            if (dataEnd) state_d = PAR;
`endif
         end
`ifdef MANCH_PARITY_EN
         PAR: begin
            half_d = ~half_q;
         end
`endif
         GAP: begin
            gap_d = gap_q + 2'd1;
            if (gap_q == GAP_LAST) begin
               state_d = IDLE;
               gap_d   = 2'd0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (byteEnd) begin
         if (last_q) begin
            state_d = GAP;
         end else if (accept) begin
            state_d = DATA;
            byte_d  = tx_data;
            last_d  = tx_last;
         end else begin
            state_d = GAP;
            under_d = 1'b1;
         end
      end

`ifdef MANCH_PARITY_EN
      finalNext = (state_d == PAR) && half_d;
`else
      finalNext = (state_d == DATA) && (bit_d == 3'd7) && half_d;
`endif
      ready_d = (state_d == IDLE) || (!last_d && finalNext);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(negedge clock or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= IDLE;
         bit_q   <= 3'd0;
         half_q  <= 1'b0;
         gap_q   <= 2'd0;
         byte_q  <= 8'd0;
         last_q  <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         under_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         half_q  <= half_d;
         gap_q   <= gap_d;
         byte_q  <= byte_d;
         last_q  <= last_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         under_q <= under_d;
      end
   end

   always_comb begin
      nrzBit = 1'b0;
      lineEn = 1'b0;
      case (state_q)
         PRE: begin
            nrzBit = PREAMBLE[bit_q];
            lineEn = 1'b1;
         end
         DATA: begin
            nrzBit = byte_q[bit_q];
            lineEn = 1'b1;
         end
`ifdef MANCH_PARITY_EN
         PAR: begin
            nrzBit = ^byte_q;
            lineEn = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   manchester_half_enc uHalfEnc (
      .clock  (clock),
      .rst_b  (rst_b),
      .en_i   (lineEn),
      .nrz_i  (nrzBit),
      .half_i (half_q),
      .line_o (B_out)
   );

   assign tx_ready = ready_q;
   assign busy     = busy_q;
   assign underrun = under_q;

endmodule

// File: tb/tb_manchester_frame_tx.sv
// Self-checking bench for manchester_frame_tx; expected line patterns are hand-encoded constants.
// Build with MANCH_PARITY_EN defined to exercise the parity variant.
module tb_manchester_frame_tx;

   typedef struct {
      logic [7:0]  data;
      logic        last;
      logic [17:0] pattern;
   } vector_t;

   typedef struct {
      logic line;
      logic ready;
      logic busy;
      logic under;
   } expect_t;

`ifdef MANCH_PARITY_EN
   localparam int BC = 18;
`else
   localparam int BC = 16;
`endif

   logic       clock;
   logic       rst_b;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       tx_ready;
   logic       B_out;
   logic       busy;
   logic       underrun;

   expect_t expQ[$];
   int      errors = 0;
   int      checks = 0;
   vector_t vecs[5];

   manchester_frame_tx dut (
      .clock    (clock),
      .rst_b    (rst_b),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_last  (tx_last),
      .tx_ready (tx_ready),
      .B_out    (B_out),
      .busy     (busy),
      .underrun (underrun)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic last, input logic valid);
      tx_data  = data;
      tx_last  = last;
      tx_valid = valid;
   endtask

   // Pushes one expected sample per clock, starting with the accept edge (k=0) and
   // ending with the first IDLE clock after the gap.
   task automatic pushFrame(input int nBytes, input logic [17:0] pat0,
                            input logic [17:0] pat1, input logic finalLast);
      int          frameEnd;
      int          idx;
      logic [17:0] pat;
      logic [15:0] pre;
      expect_t     e;
      frameEnd = 16 + nBytes * BC;
      pre = 16'h9999;
      for (int k = 0; k <= frameEnd + 4; k++) begin
         e.line = 1'b0;
         if (k >= 1 && k <= 16) begin
            e.line = pre[16 - k];
         end else if (k > 16 && k <= frameEnd) begin
            idx = k - 17;
            pat = (idx / BC == 0) ? pat0 : pat1;
            e.line = pat[17 - (idx % BC)];
         end
         e.busy  = (k < frameEnd + 4);
         e.ready = (k == frameEnd + 4) || (nBytes == 2 && k == 16 + BC - 1) ||
                   (!finalLast && k == frameEnd - 1);
         e.under = !finalLast && (k == frameEnd);
         expQ.push_back(e);
      end
   endtask

   task automatic checkOutput(input string tag, input int k);
      expect_t e;
      @(negedge clock);
      #1;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         check($sformatf("%s k=%0d B_out", tag, k), B_out, e.line);
         check($sformatf("%s k=%0d tx_ready", tag, k), tx_ready, e.ready);
         check($sformatf("%s k=%0d busy", tag, k), busy, e.busy);
         check($sformatf("%s k=%0d underrun", tag, k), underrun, e.under);
      end
   endtask

   initial begin
      int frameEnd;
      clock = 1'b0;
      rst_b = 1'b0;
      applyStimulus(8'h00, 1'b0, 1'b0);

      vecs[0] = '{8'hA5, 1'b1, {16'h9966, 2'b01}};
      vecs[1] = '{8'h00, 1'b1, {16'h5555, 2'b01}};
      vecs[2] = '{8'hFF, 1'b1, {16'hAAAA, 2'b01}};
      vecs[3] = '{8'h07, 1'b1, {16'hA955, 2'b10}};
      vecs[4] = '{8'h3C, 1'b0, {16'h5AA5, 2'b01}};

      #2;
      check("reset B_out", B_out, 1'b0);
      check("reset tx_ready", tx_ready, 1'b0);
      check("reset busy", busy, 1'b0);
      check("reset underrun", underrun, 1'b0);
      #1 rst_b = 1'b1;
      @(negedge clock);
      #1;
      check("release tx_ready", tx_ready, 1'b1);
      check("release busy", busy, 1'b0);

      // Single-byte frames; stray tx_valid pulses in PRE and GAP must be ignored.
      frameEnd = 16 + BC;
      for (int v = 0; v < 5; v++) begin
         pushFrame(1, vecs[v].pattern, 18'h0, vecs[v].last);
         applyStimulus(vecs[v].data, vecs[v].last, 1'b1);
         checkOutput($sformatf("vec%0d", v), 0);
         applyStimulus(8'h00, 1'b0, 1'b0);
         for (int k = 1; k <= frameEnd + 4; k++) begin
            checkOutput($sformatf("vec%0d", v), k);
            if (k == 5 || k == frameEnd + 1) applyStimulus(~vecs[v].data, 1'b1, 1'b1);
            else                             applyStimulus(8'h00, 1'b0, 1'b0);
         end
      end

      // Back-to-back bytes with tx_valid held until the second byte is taken.
      frameEnd = 16 + 2 * BC;
      pushFrame(2, {16'h9555, 2'b10}, {16'h5556, 2'b10}, 1'b1);
      applyStimulus(8'h01, 1'b0, 1'b1);
      checkOutput("b2b", 0);
      applyStimulus(8'h80, 1'b1, 1'b1);
      for (int k = 1; k <= frameEnd + 4; k++) begin
         checkOutput("b2b", k);
         if (k == 16 + BC) applyStimulus(8'h00, 1'b0, 1'b0);
      end

      // Reset during bit 3 of DATA, while the line is high.
      pushFrame(1, {16'h5555, 2'b01}, 18'h0, 1'b1);
      applyStimulus(8'h00, 1'b1, 1'b1);
      checkOutput("midrst", 0);
      applyStimulus(8'h00, 1'b0, 1'b0);
      for (int k = 1; k <= 22; k++) checkOutput("midrst", k);
      expQ.delete();
      #2 rst_b = 1'b0;
      #1;
      check("midrst B_out", B_out, 1'b0);
      check("midrst busy", busy, 1'b0);
      check("midrst tx_ready", tx_ready, 1'b0);
      #2 rst_b = 1'b1;
      @(negedge clock);
      #1;
      check("midrst release tx_ready", tx_ready, 1'b1);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) begin
            @(negedge clock);
            #1;
         end
         check($sformatf("midrst quiet%0d B_out", k), B_out, 1'b0);
         check($sformatf("midrst quiet%0d busy", k), busy, 1'b0);
      end

      check("queue drained", (expQ.size() == 0), 1'b1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
